// File: rtl/snapshot_checkpoint_ctrl.sv
// Checkpoint sequencer for speculative execution past predicted branches.
// Slots form a circular FIFO in program order: tail allocates, head is the oldest branch.
// A mispredict on the head slot flushes every slot and replays that slot into the register file,
// one register per cycle (reg 0 skipped), while restore_busy stalls the front end.
// Optional build macro SNAPSHOT_STATS_EN adds saturating mispredict / full-stall counters.
module snapshot_checkpoint_ctrl #(
  parameter int unsigned NUM_CKPT = 4,
  parameter int unsigned TAG_W    = $clog2(NUM_CKPT),
  parameter int unsigned NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             take_req,
  output logic             take_grant,
  output logic [TAG_W-1:0] take_tag,
  output logic             snap_wr_en,
  output logic [TAG_W-1:0] snap_wr_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispred,
  output logic [TAG_W-1:0] snap_rd_tag,
  output logic [4:0]       snap_rd_idx,
  output logic             rf_wr_en,
  output logic [4:0]       rf_wr_idx,
  output logic             restore_busy,
  output logic             full,
  output logic             empty,
  output logic             proto_err
`ifdef SNAPSHOT_STATS_EN
  ,
  output logic [31:0]      stat_mispred,
  output logic [31:0]      stat_full_stall
`endif
);

  localparam int unsigned   CntW    = TAG_W + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(NUM_CKPT);
  localparam logic [4:0]    LastIdx = 5'(NUM_REGS - 1);

  typedef enum logic [0:0] {StIdle, StRestore} state_e;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_idx_q, wr_idx_d;
  logic              perr_q, perr_d;

  logic is_idle, is_full, is_empty, grant, legal, legal_free, legal_flush;
  logic rd_active, restore_done;

  assign is_idle   = (state_q == StIdle);
  assign is_full   = (count_q == FullCnt);
  assign is_empty  = (count_q == '0);
  // Any mispredict request blocks a same-cycle take, legal or not.
  assign grant     = take_req & ~is_full & is_idle & ~(resolve_valid & resolve_mispred);
  assign legal     = resolve_valid & ~is_empty & (resolve_tag == head_q) & is_idle;
  assign legal_free  = legal & ~resolve_mispred;
  assign legal_flush = legal & resolve_mispred;
  // rd_idx_q returns to 0 once index NUM_REGS-1 has been read; the last write trails by a cycle.
  assign rd_active    = (state_q == StRestore) & (rd_idx_q != '0);
  assign restore_done = wr_en_q & (wr_idx_q == LastIdx);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter restore on a legal mispredict, leave after the final regfile write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (legal_flush)  state_d = StRestore;
      StRestore: if (restore_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    restore_busy = (state_q == StRestore);
    take_grant   = grant;
    take_tag     = grant ? tail_q : '0;
    snap_wr_en   = grant;
    snap_wr_tag  = grant ? tail_q : '0;
    snap_rd_tag  = (state_q == StRestore) ? rd_tag_q : '0;
    snap_rd_idx  = rd_active ? rd_idx_q : '0;
    rf_wr_en     = wr_en_q;
    rf_wr_idx    = wr_idx_q;
    full         = is_full;
    empty        = is_empty;
    proto_err    = perr_q;
  end

  // Pointer, occupancy and restore-sequencer next state
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q + CntW'(grant) - CntW'(legal_free);
    rd_tag_d = rd_tag_q;
    rd_idx_d = rd_idx_q;
    if (legal_free) head_d = head_q + TAG_W'(1);
    if (grant)      tail_d = tail_q + TAG_W'(1);
    if (legal_flush) begin
      // Flush the mispredicted slot and everything younger.
      tail_d   = head_q;
      count_d  = '0;
      rd_tag_d = head_q;
      rd_idx_d = 5'd1;
    end else if (rd_active) begin
      rd_idx_d = (rd_idx_q == LastIdx) ? 5'd0 : rd_idx_q + 5'd1;
    end
    // Snapshot read has one cycle of latency, so the write replays the previous read index.
    wr_en_d  = rd_active;
    wr_idx_d = rd_active ? rd_idx_q : 5'd0;
    perr_d   = resolve_valid & ~legal;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rd_tag_q <= '0;
      rd_idx_q <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rd_tag_q <= rd_tag_d;
      rd_idx_q <= rd_idx_d;
      wr_en_q  <= wr_en_d;
      wr_idx_q <= wr_idx_d;
      perr_q   <= perr_d;
    end
  end

`ifdef SNAPSHOT_STATS_EN
  logic [31:0] stat_mispred_q, stat_full_stall_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_mispred_q    <= '0;
      stat_full_stall_q <= '0;
    end else begin
      if (legal_flush && (stat_mispred_q != 32'hFFFF_FFFF)) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
      if (take_req && is_full && (stat_full_stall_q != 32'hFFFF_FFFF)) begin
        stat_full_stall_q <= stat_full_stall_q + 32'd1;
      end
    end
  end

  assign stat_mispred    = stat_mispred_q;
  assign stat_full_stall = stat_full_stall_q;
`endif

endmodule

// File: tb/tb_snapshot_checkpoint_ctrl.sv
// Bench for snapshot_checkpoint_ctrl: a queue-based model checked every cycle on the falling
// edge, plus directed scenarios with literal expectations. Honours SNAPSHOT_STATS_EN.
module tb_snapshot_checkpoint_ctrl;

  localparam int N     = 4;
  localparam int TAG_W = 2;
  localparam int NR    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             take_req = 1'b0;
  logic             take_grant;
  logic [TAG_W-1:0] take_tag;
  logic             snap_wr_en;
  logic [TAG_W-1:0] snap_wr_tag;
  logic             resolve_valid = 1'b0;
  logic [TAG_W-1:0] resolve_tag = '0;
  logic             resolve_mispred = 1'b0;
  logic [TAG_W-1:0] snap_rd_tag;
  logic [4:0]       snap_rd_idx;
  logic             rf_wr_en;
  logic [4:0]       rf_wr_idx;
  logic             restore_busy;
  logic             full;
  logic             empty;
  logic             proto_err;
`ifdef SNAPSHOT_STATS_EN
  logic [31:0]      stat_mispred;
  logic [31:0]      stat_full_stall;
`endif

  snapshot_checkpoint_ctrl #(
    .NUM_CKPT (N),
    .TAG_W    (TAG_W),
    .NUM_REGS (NR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .take_req        (take_req),
    .take_grant      (take_grant),
    .take_tag        (take_tag),
    .snap_wr_en      (snap_wr_en),
    .snap_wr_tag     (snap_wr_tag),
    .resolve_valid   (resolve_valid),
    .resolve_tag     (resolve_tag),
    .resolve_mispred (resolve_mispred),
    .snap_rd_tag     (snap_rd_tag),
    .snap_rd_idx     (snap_rd_idx),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_idx       (rf_wr_idx),
    .restore_busy    (restore_busy),
    .full            (full),
    .empty           (empty),
    .proto_err       (proto_err)
`ifdef SNAPSHOT_STATS_EN
    ,
    .stat_mispred    (stat_mispred),
    .stat_full_stall (stat_full_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outstanding tags in program order, next tag to hand out, restore cycle number
  // (0 = not restoring, 1..NR = busy cycles), pending protocol-error pulse, statistics.
  int q[$];
  int m_tail  = 0;
  int m_rc    = 0;
  int m_rdtag = 0;
  bit m_perr  = 1'b0;
  int m_smis  = 0;
  int m_sfull = 0;

  always @(negedge clk) begin : compare
    bit m_full, m_empty, busy, grant, legal;
    if (!rst_n) begin
      q.delete();
      m_tail = 0; m_rc = 0; m_rdtag = 0; m_perr = 1'b0; m_smis = 0; m_sfull = 0;
    end
    m_full  = (q.size() == N);
    m_empty = (q.size() == 0);
    busy    = (m_rc != 0);
    grant   = take_req && !m_full && !busy && !(resolve_valid && resolve_mispred);
    chk("take_grant",   32'(take_grant),   32'(grant));
    chk("take_tag",     32'(take_tag),     grant ? 32'(m_tail) : 32'd0);
    chk("snap_wr_en",   32'(snap_wr_en),   32'(grant));
    chk("snap_wr_tag",  32'(snap_wr_tag),  grant ? 32'(m_tail) : 32'd0);
    chk("snap_rd_tag",  32'(snap_rd_tag),  busy ? 32'(m_rdtag) : 32'd0);
    chk("snap_rd_idx",  32'(snap_rd_idx),  (m_rc >= 1 && m_rc <= NR - 1) ? 32'(m_rc) : 32'd0);
    chk("rf_wr_en",     32'(rf_wr_en),     32'(m_rc >= 2));
    chk("rf_wr_idx",    32'(rf_wr_idx),    (m_rc >= 2) ? 32'(m_rc - 1) : 32'd0);
    chk("restore_busy", 32'(restore_busy), 32'(busy));
    chk("full",         32'(full),         32'(m_full));
    chk("empty",        32'(empty),        32'(m_empty));
    chk("proto_err",    32'(proto_err),    32'(m_perr));
`ifdef SNAPSHOT_STATS_EN
    chk("stat_mispred",    stat_mispred,    32'(m_smis));
    chk("stat_full_stall", stat_full_stall, 32'(m_sfull));
`endif
    if (rst_n) begin
      legal = resolve_valid && !busy && !m_empty && (int'(resolve_tag) == q[0]);
      if (take_req && m_full) m_sfull++;
      if (legal && resolve_mispred) m_smis++;
      m_perr = resolve_valid && !legal;
      if (busy) begin
        m_rc = (m_rc == NR) ? 0 : m_rc + 1;
      end else begin
        if (legal && !resolve_mispred) void'(q.pop_front());
        if (grant) begin
          q.push_back(m_tail);
          m_tail = (m_tail + 1) % N;
        end
        if (legal && resolve_mispred) begin
          m_rdtag = q[0];
          m_tail  = q[0];
          q.delete();
          m_rc = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    take_req = 1'b0; resolve_valid = 1'b0; resolve_mispred = 1'b0; resolve_tag = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Counts busy cycles from now until restore_busy drops, bounded.
  task automatic wait_restore(output int nb, output int nw, input bit poke);
    nb = 0; nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (!restore_busy) break;
      nb++;
      if (rf_wr_en) begin
        chk("wr_idx_seq", 32'(rf_wr_idx), 32'(nw + 1));
        nw++;
      end
      resolve_valid = poke && (c == 5);
      tick();
    end
    resolve_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nb, nw;
    repeat (2) tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(restore_busy), 32'd0);
    rst_n = 1'b1;

    // Four consecutive takes, then a refused fifth.
    for (int i = 0; i < 4; i++) begin
      take_req = 1'b1;
      #1;
      chk("take4_grant", 32'(take_grant), 32'd1);
      chk("take4_tag", 32'(take_tag), 32'(i));
      tick();
    end
    chk("take4_full", 32'(full), 32'd1);
    #1;
    chk("take5_refused", 32'(take_grant), 32'd0);
    tick();

    // Free head while full: same-cycle take refused, next cycle wraps to tag 0.
    resolve_valid = 1'b1; resolve_tag = 2'd0; resolve_mispred = 1'b0;
    #1;
    chk("free_take_refused", 32'(take_grant), 32'd0);
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("wrap_grant", 32'(take_grant), 32'd1);
    chk("wrap_tag", 32'(take_tag), 32'd0);
    tick();
    take_req = 1'b0;
    chk("wrap_full", 32'(full), 32'd1);

    // Out-of-order resolve: head is 1, resolve tag 3.
    resolve_valid = 1'b1; resolve_tag = 2'd3;
    tick();
    resolve_valid = 1'b0;
    chk("perr_pulse", 32'(proto_err), 32'd1);
    chk("perr_full_kept", 32'(full), 32'd1);
    tick();
    chk("perr_one_cycle", 32'(proto_err), 32'd0);

    // Tags 0..2 outstanding, mispredict tag 0 with a take in the same cycle.
    do_reset();
    take_req = 1'b1;
    repeat (3) tick();
    resolve_valid = 1'b1; resolve_tag = 2'd0; resolve_mispred = 1'b1;
    #1;
    chk("mis_take_dropped", 32'(take_grant), 32'd0);
    tick();
    take_req = 1'b0; resolve_valid = 1'b0; resolve_mispred = 1'b0;
    wait_restore(nb, nw, 1'b1);
    chk("restore_busy_cycles", 32'(nb), 32'd32);
    chk("restore_writes", 32'(nw), 32'd31);
    chk("restore_empty", 32'(empty), 32'd1);

    // Reset in the middle of a restore.
    take_req = 1'b1;
    tick();
    take_req = 1'b0;
    resolve_valid = 1'b1; resolve_tag = 2'd0; resolve_mispred = 1'b1;
    tick();
    resolve_valid = 1'b0; resolve_mispred = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", 32'(restore_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("midrst_busy", 32'(restore_busy), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Three mispredicts, then five cycles of take_req while full.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      take_req = 1'b1;
      tick();
      take_req = 1'b0;
      resolve_valid = 1'b1; resolve_tag = 2'd0; resolve_mispred = 1'b1;
      tick();
      resolve_valid = 1'b0; resolve_mispred = 1'b0;
      wait_restore(nb, nw, 1'b0);
    end
    take_req = 1'b1;
    repeat (4) tick();
    repeat (5) tick();
    take_req = 1'b0;
`ifdef SNAPSHOT_STATS_EN
    chk("stat_mispred_3", stat_mispred, 32'd3);
    chk("stat_full_stall_5", stat_full_stall, 32'd5);
`endif
    chk("stats_full", 32'(full), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
